// File: rtl/ascon_permutation_pkg.sv
// Shared definitions for the Ascon permutation: FSM encoding, legal round
// counts, linear-layer rotation amounts, the 5-bit S-box and small helpers.
package ascon_permutation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FIN   = 2'd3
    } fsm_state_e;

    localparam logic [3:0] ROUNDS_6  = 4'd6;
    localparam logic [3:0] ROUNDS_8  = 4'd8;
    localparam logic [3:0] ROUNDS_12 = 4'd12;

    // Right-rotation pair applied to word xN in the linear layer
    localparam int unsigned ROT_A [5] = '{32'd19, 32'd61, 32'd1, 32'd10, 32'd7};
    localparam int unsigned ROT_B [5] = '{32'd28, 32'd39, 32'd6, 32'd17, 32'd41};

    // Index is {x0,x1,x2,x3,x4} bit column, x0 as MSB; output uses same order
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic rounds_legal(input logic [3:0] n);
        return (n == ROUNDS_6) || (n == ROUNDS_8) || (n == ROUNDS_12);
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (32'd64 - n));
    endfunction

    // Constant for absolute round index i (0..11 of the full 12-round schedule)
    function automatic logic [7:0] rc_value(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

endpackage

// File: rtl/ascon_permutation_round_constant.sv
// Round-constant source: after start, emits one registered r_con per cycle,
// beginning at schedule index 12-rounds; done marks the final constant.
module round_constant
    import ascon_permutation_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rounds,
    output logic [7:0] r_con,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'd11;

    logic [3:0] idx_r;
    logic       active_r;
    logic [7:0] r_con_r;
    logic       done_r;
    logic [3:0] first_idx_s;
    logic [3:0] next_idx_s;

    assign first_idx_s = 4'd12 - rounds;
    assign next_idx_s  = idx_r + 4'd1;

    // Schedule index, active flag and registered constant/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r    <= 4'd0;
            active_r <= 1'b0;
            r_con_r  <= 8'd0;
            done_r   <= 1'b0;
        end else if (start) begin
            idx_r    <= first_idx_s;
            active_r <= 1'b1;
            r_con_r  <= rc_value(first_idx_s);
            done_r   <= (first_idx_s == LAST_IDX);
        end else if (active_r) begin
            if (idx_r == LAST_IDX) begin
                active_r <= 1'b0;
                r_con_r  <= 8'd0;
                done_r   <= 1'b0;
            end else begin
                idx_r    <= next_idx_s;
                r_con_r  <= rc_value(next_idx_s);
                done_r   <= (next_idx_s == LAST_IDX);
            end
        end else begin
            r_con_r <= 8'd0;
            done_r  <= 1'b0;
        end
    end

    assign r_con = r_con_r;
    assign done  = done_r;

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: one full round per clock over a 320-bit state,
// with round constants supplied by a round_constant instance.
module ascon_permutation
    import ascon_permutation_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in,
    output logic [319:0] state_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    fsm_state_e       state_r;
    fsm_state_e       next_state_s;
    logic [0:4][63:0] x_r;
    logic [319:0]     state_out_r;
    logic [3:0]       rounds_r;
    logic [3:0]       round_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             rc_start_s;
    logic [7:0]       r_con_s;
    logic             rc_done_s;
    logic             legal_s;
    logic             last_round_s;
    logic [0:4][63:0] add_s;
    logic [0:4][63:0] sbox_s;
    logic [0:4][63:0] round_s;
    logic [4:0]       col_s;

    round_constant u_round_constant (
        .clk    (clk),
        .rst    (rst),
        .start  (rc_start_s),
        .rounds (rounds_r),
        .r_con  (r_con_s),
        .done   (rc_done_s)
    );

    assign legal_s      = rounds_legal(rounds_r);
    assign last_round_s = rc_done_s | (round_cnt_r == rounds_r - 4'd1);

    // One Ascon round: constant into x2, bit-sliced S-box, then linear diffusion
    always_comb begin
        add_s       = x_r;
        add_s[2]    = x_r[2] ^ {56'd0, r_con_s};
        sbox_s      = '0;
        round_s     = '0;
        col_s       = 5'd0;
        for (int i = 0; i < 64; i++) begin
            col_s = SBOX[{add_s[0][i], add_s[1][i], add_s[2][i], add_s[3][i], add_s[4][i]}];
            sbox_s[0][i] = col_s[4];
            sbox_s[1][i] = col_s[3];
            sbox_s[2][i] = col_s[2];
            sbox_s[3][i] = col_s[1];
            sbox_s[4][i] = col_s[0];
        end
        for (int j = 0; j < 5; j++) begin
            round_s[j] = sbox_s[j] ^ ror64(sbox_s[j], ROT_A[j]) ^ ror64(sbox_s[j], ROT_B[j]);
        end
    end

    // Next-state and round-constant start control
    always_comb begin
        next_state_s = state_r;
        rc_start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rc_start_s = 1'b1;
                if (legal_s) begin
                    next_state_s = ST_ROUND;
                end else begin
                    next_state_s = ST_FIN;
                end
            end
            ST_ROUND: begin
                if (last_round_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_ROUND;
                end
            end
            ST_FIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, working state, round counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            x_r         <= '0;
            state_out_r <= 320'd0;
            rounds_r    <= 4'd0;
            round_cnt_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_FIN);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r      <= state_in;
                        rounds_r <= rounds;
                        err_r    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    round_cnt_r <= 4'd0;
                    err_r       <= ~legal_s;
                    // Illegal count skips the rounds and publishes the input untouched
                    if (!legal_s) begin
                        state_out_r <= x_r;
                    end
                end
                ST_ROUND: begin
                    x_r         <= round_s;
                    round_cnt_r <= round_cnt_r + 4'd1;
                    if (last_round_s) begin
                        state_out_r <= round_s;
                    end
                end
                default: begin
                    round_cnt_r <= round_cnt_r;
                end
            endcase
        end
    end

    assign state_out = state_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_ascon_permutation.sv
// Randomised self-checking bench for ascon_permutation against a bit-sliced
// Boolean-instruction reference of the Ascon permutation.
module tb_ascon_permutation;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic [319:0] state_out;
    logic         busy;
    logic         done;
    logic         err;

    int vectors;
    int miscompares;

    ascon_permutation dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rounds    (rounds),
        .state_in  (state_in),
        .state_out (state_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int r);
        logic [127:0] d;
        d = {v, v} >> r;
        return d[63:0];
    endfunction

    function automatic logic [7:0] ref_rc(input int n, input int k);
        int base;
        base = 12 - n;
        return 8'((((15 - base - k) & 15) << 4) | ((base + k) & 15));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        if (!(n == 6 || n == 8 || n == 12)) return s;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        for (int k = 0; k < n; k++) begin
            x2 = x2 ^ {56'd0, ref_rc(n, k)};
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
            x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
            x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
            x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
            x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive start for one cycle; returns at the falling edge of cycle 1
    task automatic launch(input logic [319:0] s, input int n);
        @(negedge clk);
        state_in = s;
        rounds   = 4'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rounds = 4'd12; state_in = rand320();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b, want 0 0 0", busy, done, err);
        end
        vectors++;
        if (state_out !== 320'd0) begin
            miscompares++;
            $display("FAIL reset_state_out: got %h, want 0", state_out);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_dropped: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_zero_state();
        logic [319:0] exp;
        int cyc;
        exp = ref_perm(320'd0, 12);
        launch(320'd0, 12);
        for (cyc = 1; cyc <= 14; cyc++) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_busy c%0d: got %b, want 1", cyc, busy);
            end
            vectors++;
            if (done !== (cyc == 14)) begin
                miscompares++;
                $display("FAIL zero_done c%0d: got %b, want %b", cyc, done, (cyc == 14));
            end
            if (cyc >= 2 && cyc <= 13) begin
                vectors++;
                if (dut.u_round_constant.r_con !== ref_rc(12, cyc - 2)) begin
                    miscompares++;
                    $display("FAIL zero_rcon k%0d: got %h, want %h", cyc - 2,
                             dut.u_round_constant.r_con, ref_rc(12, cyc - 2));
                end
            end
            if (cyc == 14) begin
                vectors++;
                if (state_out !== exp || err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero_out: got %h err=%b, want %h err=0", state_out, err, exp);
                end
            end
            if (cyc < 14) @(negedge clk);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [319:0] s;
        int cyc;
        int n;
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 6 : 8;
            s = rand320();
            launch(s, n);
            @(negedge clk);
            vectors++;
            if (dut.u_round_constant.r_con !== ((n == 6) ? 8'h96 : 8'hB4)) begin
                miscompares++;
                $display("FAIL b2b_first_rcon n%0d: got %h, want %h", n,
                         dut.u_round_constant.r_con, (n == 6) ? 8'h96 : 8'hB4);
            end
            wait_done(2, cyc);
            vectors++;
            if (cyc !== n + 2) begin
                miscompares++;
                $display("FAIL b2b_latency n%0d: got %0d, want %0d", n, cyc, n + 2);
            end
            vectors++;
            if (state_out !== ref_perm(s, n) || err !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_out n%0d: got %h err=%b, want %h", n, state_out, err, ref_perm(s, n));
            end
        end
    endtask

    task automatic test_illegal();
        logic [319:0] s;
        int cyc;
        s = rand320();
        launch(s, 5);
        wait_done(1, cyc);
        vectors++;
        if (cyc !== 2 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_done: cycle=%0d err=%b, want 2 1", cyc, err);
        end
        vectors++;
        if (state_out !== s) begin
            miscompares++;
            $display("FAIL illegal_passthru: got %h, want %h", state_out, s);
        end
        s = rand320();
        launch(s, 8);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_err_clear: got %b, want 0", err);
        end
        wait_done(1, cyc);
        vectors++;
        if (cyc !== 10 || state_out !== ref_perm(s, 8) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_next_run: cycle=%0d err=%b out=%h, want 10 0 %h",
                     cyc, err, state_out, ref_perm(s, 8));
        end
    endtask

    task automatic test_ignored_start();
        logic [319:0] s;
        int dones;
        s = rand320();
        dones = 0;
        launch(s, 12);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done === 1'b1) dones++;
            if (cyc <= 14) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ignore_busy c%0d: got %b, want 1", cyc, busy);
                end
            end
            if (cyc == 14) begin
                vectors++;
                if (done !== 1'b1 || state_out !== ref_perm(s, 12)) begin
                    miscompares++;
                    $display("FAIL ignore_out: done=%b got %h, want 1 %h", done, state_out, ref_perm(s, 12));
                end
            end
            if (cyc == 15) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ignore_start_at_done: busy=%b, want 0", busy);
                end
            end
            start    = (cyc == 3 || cyc == 13 || cyc == 14);
            rounds   = 4'd6;
            state_in = rand320();
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignore_done_count: got %0d, want 1", dones);
        end
    endtask

    task automatic test_reset_abort();
        logic [319:0] s;
        int dones;
        int cyc;
        dones = 0;
        launch(rand320(), 12);
        for (int c = 1; c <= 25; c++) begin
            if (done === 1'b1) dones++;
            if (c == 6) begin
                vectors++;
                if (busy !== 1'b0 || state_out !== 320'd0) begin
                    miscompares++;
                    $display("FAIL abort_cleared: busy=%b out=%h, want 0 0", busy, state_out);
                end
            end
            rst = (c == 5);
            @(negedge clk);
        end
        rst = 1'b0;
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
        s = rand320();
        launch(s, 8);
        wait_done(1, cyc);
        vectors++;
        if (cyc !== 10 || state_out !== ref_perm(s, 8)) begin
            miscompares++;
            $display("FAIL abort_rerun: cycle=%0d out=%h, want 10 %h", cyc, state_out, ref_perm(s, 8));
        end
    endtask

    task automatic test_random();
        logic [319:0] s;
        int n;
        int cyc;
        int sel;
        for (int it = 0; it < 10; it++) begin
            s   = rand320();
            sel = $urandom_range(0, 3);
            case (sel)
                0:       n = 6;
                1:       n = 8;
                2:       n = 12;
                default: n = (int'($urandom_range(0, 15)) | 1) & 15;
            endcase
            launch(s, n);
            wait_done(1, cyc);
            vectors++;
            if (cyc !== ((n == 6 || n == 8 || n == 12) ? n + 2 : 2)) begin
                miscompares++;
                $display("FAIL rand_latency n%0d: got %0d", n, cyc);
            end
            vectors++;
            if (state_out !== ref_perm(s, n) || err !== !(n == 6 || n == 8 || n == 12)) begin
                miscompares++;
                $display("FAIL rand_out n%0d: got %h err=%b, want %h", n, state_out, err, ref_perm(s, n));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        rounds      = 4'd0;
        state_in    = 320'd0;
        test_reset();
        test_zero_state();
        test_back_to_back();
        test_illegal();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
